// File: rtl/accum_controller.sv
`default_nettype none
// ============================================================================
// Module      : accum_controller
// Description : Sequencer for a LEN-beat accumulate over a valid/ready stream
//               with sticky carry-out and a held valid/ready result port.
// Revision    : 1.0
// ============================================================================
module accum_controller #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic [LEN_W-1:0] beats
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [LEN_W-1:0] C_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [LEN_W-1:0] r_beats;
    logic [LEN_W-1:0] r_remaining;
    logic [WIDTH:0]   w_sum;
    logic             w_fire;
    logic             w_last;

    assign w_fire = (r_state == S_ACCUM) && in_valid;
    assign w_last = w_fire && (r_remaining == C_ONE);
    assign w_sum  = {1'b0, r_acc} + {1'b0, in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator state survives the return to IDLE until the next start clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_beats     <= '0;
            r_remaining <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_beats     <= '0;
            r_remaining <= len;
        end else if (w_fire) begin
            r_acc       <= w_sum[WIDTH-1:0];
            r_ovf       <= r_ovf | w_sum[WIDTH];
            r_beats     <= r_beats + C_ONE;
            r_remaining <= r_remaining - C_ONE;
        end
    end

    assign out_data = r_acc;
    assign out_ovf  = r_ovf;
    assign beats    = r_beats;

endmodule
`default_nettype wire

// File: tb/tb_accum_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_controller
// Description : Directed and randomized checks of accum_controller against a
//               sum-of-operands reference.
// Revision    : 1.0
// ============================================================================
module tb_accum_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] len;
    logic       busy;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ovf;
    logic       out_ready;
    logic [3:0] beats;

    int nerr = 0;
    int nchk = 0;
    int q[$];

    accum_controller #(.WIDTH(4), .LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_ready (out_ready),
        .beats     (beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result is the plain sum mod 16; a carry occurred iff the true sum reached 16.
    task automatic run_cmd(input int n, input int gap, input int hold, input bit poke);
        int sum;
        int d;
        sum   = 0;
        start = 1'b1;
        len   = n[3:0];
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("beats_cleared", beats, 0);
        for (int i = 0; i < n; i++) begin
            d        = (i < q.size()) ? q[i] : int'($urandom_range(0, 15));
            in_valid = 1'b1;
            in_data  = d[3:0];
            if (poke && i == 0) begin
                start = 1'b1;
                len   = 4'd3;
            end
            chk("in_ready_accum", in_ready, 1);
            step();
            in_valid = 1'b0;
            start    = 1'b0;
            sum += d;
            chk("beats_step", beats, i + 1);
            for (int g = 0; g < gap && i < n - 1; g++) begin
                in_data = 4'($urandom);
                step();
                chk("gap_in_ready", in_ready, 1);
                chk("gap_beats", beats, i + 1);
            end
        end
        q.delete();
        chk("out_valid", out_valid, 1);
        chk("in_ready_done", in_ready, 0);
        chk("out_data", out_data, sum % 16);
        chk("out_ovf", out_ovf, (sum >= 16) ? 1 : 0);
        chk("beats_final", beats, n);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            in_data  = 4'($urandom);
            step();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, sum % 16);
            chk("hold_beats", beats, n);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (poke) begin
            start = 1'b1;
            len   = 4'd5;
        end
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_beats_kept", beats, n);
        chk("post_data_kept", out_data, sum % 16);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_beats", beats, 0);
        reset = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        q = '{0, 1, 2, 3};
        run_cmd(4, 0, 0, 1'b0);

        q = '{9, 8, 1};
        run_cmd(3, 2, 1, 1'b0);

        run_cmd(0, 0, 5, 1'b0);

        q = '{1, 2, 3};
        run_cmd(3, 0, 0, 1'b1);
        q = '{15};
        run_cmd(1, 0, 0, 1'b0);

        // Abort mid-command with an asynchronous reset between clock edges.
        start = 1'b1;
        len   = 4'd5;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd3;
        step();
        in_data = 4'd4;
        step();
        in_valid = 1'b0;
        chk("abort_beats", beats, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_out_ovf", out_ovf, 0);
        chk("async_beats", beats, 0);
        #3 reset = 1'b0;
        step();
        chk("after_abort_busy", busy, 0);
        q = '{5, 5};
        run_cmd(2, 0, 0, 1'b0);

        q = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15};
        run_cmd(15, 0, 2, 1'b0);

        repeat (8) begin
            run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accum_controller.md
Name: accum_controller

Overview:
- Sequencer for the 4-bit accumulate datapath (adder + running-sum register + beat counter).
- On a start command it accepts exactly LEN operands over a valid/ready stream and sums them modulo 2^WIDTH with sticky carry-out detection.
- It then holds the result on a valid/ready output port until the consumer takes it.
- It sits between an operand producer and a result consumer and owns the clear, enable and counting of the accumulator.

Parameters:
- WIDTH, 4, operand and accumulator width in bits
- LEN_W, 4, width of the length field and beat counter; max LEN = 2^LEN_W - 1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- len  input  LEN_W  number of operands to accumulate; sampled with start
- busy  output  1  high in ACCUM and DONE
- in_valid  input  1  operand valid
- in_data  input  WIDTH  operand
- in_ready  output  1  operand accepted when in_valid && in_ready
- out_valid  output  1  result valid
- out_data  output  WIDTH  accumulated sum modulo 2^WIDTH
- out_ovf  output  1  sticky: any addition in this command produced carry-out
- out_ready  input  1  result taken when out_valid && out_ready
- beats  output  LEN_W  operands accepted so far in the current command

Behaviour:
- Reset (asynchronous, active-high) forces the following, independent of clk:
  - state = IDLE
  - accumulator = 0, ovf = 0, beats = 0, remaining = 0
  - all outputs 0 (busy, in_ready, out_valid, out_data, out_ovf, beats)
- Reset asserted mid-command aborts the command. No result is produced, and operands already accepted are discarded.
- State machine, states IDLE, ACCUM, DONE; all outputs registered or decoded from state only (no combinational input-to-output paths):
  - IDLE:
    - busy = 0, in_ready = 0, out_valid = 0.
    - start && len != 0: latch remaining = len, clear accumulator, ovf and beats; next state ACCUM.
    - start && len == 0: clear accumulator, ovf and beats; next state DONE (result 0, ovf 0).
    - No start: stay in IDLE.
  - ACCUM:
    - busy = 1, in_ready = 1.
    - On each handshake:
      - acc <= (acc + in_data) mod 2^WIDTH
      - ovf <= ovf | carry-out of the (WIDTH+1)-bit sum
      - beats <= beats + 1, remaining <= remaining - 1
    - A handshake with remaining == 1 moves the FSM to DONE. in_ready drops on the next cycle.
    - in_valid low: hold all state, no stall limit.
  - DONE:
    - busy = 1, out_valid = 1, in_ready = 0.
    - out_data = acc and out_ovf = ovf, held stable while out_ready is low.
    - out_ready high: next state IDLE. out_valid drops the next cycle; acc, ovf and beats keep their last values until the next start.
- start while busy (ACCUM or DONE) is ignored, including a start in the same cycle as the final out_ready handshake. A new command needs at least one cycle in IDLE.
- Latency:
  - Last operand accepted at edge k: out_valid high from edge k; earliest consumer handshake at edge k+1.
  - Single-beat command: start at edge 0, operand at edge 1, result visible after edge 1.
- Throughput: one operand per cycle while in_valid is held high.
- Widths:
  - Adder is WIDTH+1 bits wide; the MSB feeds ovf and is not stored in acc.
  - beats wraps only at 2^LEN_W, which cannot occur because len ≤ 2^LEN_W - 1.
- in_valid or in_data toggling outside ACCUM has no effect.

Test Plan:
1. Reset, then start len=4 with operands 0, 1, 2, 3 back-to-back → in_ready high 4 cycles; out_valid one cycle after last beat; out_data=6, out_ovf=0, beats=4.
2. len=3, operands 9, 8, 1 with in_valid gaps of 2 cycles between beats → out_data=2 (18 mod 16), out_ovf=1; in_ready stays high through gaps; beats steps 1, 2, 3.
3. start with len=0 → DONE next cycle, out_data=0, out_ovf=0, beats=0; out_ready held low 5 cycles, then outputs stable; out_ready high → IDLE, busy=0.
4. start pulsed during ACCUM and in the cycle of the final out_ready handshake → both ignored; a start one cycle later with len=1, operand 15 → out_data=15, out_ovf=0.
5. Reset asserted asynchronously mid-edge after 2 of 5 operands (acc=7) → all outputs 0 immediately, FSM in IDLE; next command len=2, operands 5, 5 → out_data=10, out_ovf=0.
6. len=15, all operands 15 → out_data=1 (225 mod 16), out_ovf=1, beats=15, 15 consecutive accept cycles.
